// File: rtl/vga_pixel_fetch_if.sv
// Read-only word bus between the pixel prefetcher (master) and the CPU data memory (slave).
interface vga_pixel_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/vga_pixel_fetch.sv
// Prefetches the 8bpp frame image as 32-bit words into a small FIFO and
// hands the display one pixel per request, restarting on every frame_start.
module vga_pixel_fetch #(
  parameter int BASE_ADDR  = 24,
  parameter int NUM_PX     = 90000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              px_req,
  output logic              px_valid,
  output logic [7:0]        px_data,
  output logic              underflow,
  vga_pixel_fetch_if.master mem
);
  localparam int NUM_WORDS = NUM_PX / 4;
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]       BASE_C    = 32'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state;
  logic [31:0]       word_ptr;
  logic [WCNT_W-1:0] words_issued;
  logic              discard;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [1:0]        byte_idx;
  logic [31:0]       head_word;
  logic              push;
  logic              pop_px;
  logic              pop_word;

  // frame_start wins over both a pixel pop and a landing response
  assign push      = (state == WAIT) && mem.mem_rvalid && !discard && !frame_start;
  assign pop_px    = px_req && px_valid && !frame_start;
  assign pop_word  = pop_px && (byte_idx == 2'd3);
  assign px_valid  = (fifo_count != '0);
  assign head_word = fifo_mem[rd_ptr];
  assign px_data   = px_valid ? head_word[{byte_idx, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      byte_idx   <= '0;
      underflow  <= 1'b0;
    end else if (frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      byte_idx   <= '0;
    end else begin
      if (push)     wr_ptr   <= wr_ptr + 1'b1;
      if (pop_word) rd_ptr   <= rd_ptr + 1'b1;
      if (pop_px)   byte_idx <= byte_idx + 1'b1;
      if (push && !pop_word)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop_word) fifo_count <= fifo_count - 1'b1;
      if (px_req && !px_valid) underflow <= 1'b1;
    end
  end

  // A request raised or in flight when a frame restarts still finishes on the
  // bus; discard marks its data as stale so the new frame starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= BASE_C;
      word_ptr     <= BASE_C;
      words_issued <= '0;
      discard      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (frame_start) begin
            state        <= REQ;
            word_ptr     <= BASE_C;
            words_issued <= '0;
          end
        end
        REQ: begin
          if (mem.mem_req) begin
            if (frame_start) begin
              discard      <= 1'b1;
              word_ptr     <= BASE_C;
              words_issued <= '0;
            end else if (mem.mem_gnt && !discard) begin
              word_ptr     <= word_ptr + 32'd4;
              words_issued <= words_issued + 1'b1;
            end
            if (mem.mem_gnt) begin
              mem.mem_req <= 1'b0;
              state       <= WAIT;
            end
          end else if (frame_start) begin
            word_ptr     <= BASE_C;
            words_issued <= '0;
          end else if (fifo_count < DEPTH_C) begin
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= word_ptr;
          end
        end
        WAIT: begin
          if (frame_start) begin
            discard      <= 1'b1;
            word_ptr     <= BASE_C;
            words_issued <= '0;
          end
          if (mem.mem_rvalid) begin
            discard <= 1'b0;
            if (frame_start || discard)        state <= REQ;
            else if (words_issued == LAST_WORD) state <= DONE;
            else                                state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomised scoreboard bench: a frame_start pushes the whole expected pixel
// stream; a monitor pops and compares on every accepted pixel.
module tb_vga_pixel_fetch;
  localparam int BASE_ADDR  = 24;
  localparam int NUM_PX     = 256;
  localparam int FIFO_DEPTH = 8;
  localparam int NUM_WORDS  = NUM_PX / 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       px_req = 1'b0;
  logic       px_valid;
  logic [7:0] px_data;
  logic       underflow;

  vga_pixel_fetch_if bus();

  vga_pixel_fetch #(.BASE_ADDR(BASE_ADDR), .NUM_PX(NUM_PX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .px_req(px_req),
    .px_valid(px_valid), .px_data(px_data), .underflow(underflow), .mem(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] image [NUM_WORDS];
  logic [7:0]  exp_px [$];
  logic [31:0] gnt_log [$];
  int          pop_count = 0;
  int          rvalid_count = 0;
  int          gnt_max = 0;
  int          rsp_max = 0;
  int          rsp_fixed = 0;
  bit          gnt_block = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit fs, input bit req);
    logic [31:0] w;
    @(posedge clk);
    #1;
    frame_start = fs;
    px_req      = req;
    if (fs) begin
      exp_px.delete();
      gnt_log.delete();
      for (int i = 0; i < NUM_PX; i++) begin
        w = image[i / 4];
        exp_px.push_back(w[8 * (i % 4) +: 8]);
      end
    end
  endtask

  // mode 0: request only when valid, 1: request every cycle, 2: random gaps
  task automatic popPixels(input int n, input int mode);
    int target = pop_count + n;
    int budget = 20000;
    while (pop_count < target && budget > 0) begin
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      if (pop_count >= target)  px_req = 1'b0;
      else if (mode == 1)       px_req = 1'b1;
      else if (mode == 2)       px_req = px_valid && ($urandom_range(0, 2) != 0);
      else                      px_req = px_valid;
      budget--;
    end
    @(posedge clk);
    #1;
    px_req = 1'b0;
    if (budget == 0) checkOutput("pop_timeout", pop_count, target);
  endtask

  task automatic waitValid(input string name);
    int budget = 200;
    while (!px_valid && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (budget == 0) checkOutput(name, px_valid, 1);
  endtask

  // Pixel monitor: every accepted pixel must be the next byte of the image
  always @(negedge clk) begin
    if (rst_n) begin
      if (px_req && px_valid && !frame_start) begin
        if (exp_px.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL px_extra: got 0x%0h expected no pixel at %0t", px_data, $time);
        end else begin
          checkOutput("px_data", px_data, exp_px.pop_front());
        end
        pop_count++;
      end else if (!px_valid) begin
        checkOutput("px_data_idle", px_data, 8'h00);
      end
    end
  end

  // Memory slave with random grant and response latency
  bit          prev_wait_req = 1'b0;
  logic [31:0] prev_addr = '0;
  int          gnt_cnt = 0;
  int          rsp_cnt = 0;
  bit          rsp_pending = 1'b0;
  logic [31:0] rsp_addr = '0;

  always @(negedge clk) begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    if (!rst_n) begin
      rsp_pending   = 1'b0;
      prev_wait_req = 1'b0;
      gnt_cnt       = 0;
    end else begin
      if (prev_wait_req) begin
        checkOutput("req_held", bus.mem_req, 1'b1);
        checkOutput("addr_held", bus.mem_addr, prev_addr);
      end
      if (rsp_pending) begin
        if (rsp_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = image[(rsp_addr - BASE_ADDR) / 4];
          rsp_pending    = 1'b0;
          rvalid_count++;
        end else begin
          rsp_cnt--;
        end
      end
      if (bus.mem_req && !gnt_block) begin
        if (gnt_cnt == 0) begin
          checkOutput("addr_range", (bus.mem_addr >= BASE_ADDR) &&
                      (bus.mem_addr < BASE_ADDR + 4 * NUM_WORDS) && (bus.mem_addr[1:0] == 2'b00), 1'b1);
          bus.mem_gnt = 1'b1;
          rsp_pending = 1'b1;
          rsp_addr    = bus.mem_addr;
          rsp_cnt     = (rsp_fixed >= 0) ? rsp_fixed : $urandom_range(0, rsp_max);
          gnt_cnt     = $urandom_range(0, gnt_max);
          gnt_log.push_back(bus.mem_addr);
        end else begin
          gnt_cnt--;
        end
      end
      prev_wait_req = bus.mem_req && !bus.mem_gnt;
      prev_addr     = bus.mem_addr;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rv;
    int budget;
    for (int i = 0; i < NUM_WORDS; i++) image[i] = $urandom;
    image[0] = 32'h44332211;
    image[1] = 32'h88776655;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", bus.mem_req, 1'b0);
    checkOutput("rst_mem_addr", bus.mem_addr, BASE_ADDR);
    checkOutput("rst_px_valid", px_valid, 1'b0);
    checkOutput("rst_px_data", px_data, 8'h00);
    checkOutput("rst_underflow", underflow, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] fast memory, continuous pixel demand");
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    waitValid("first_valid_timeout");
    popPixels(64, 1);
    checkOutput("gnt0_addr", gnt_log[0], 24);
    checkOutput("gnt1_addr", gnt_log[1], 28);
    checkOutput("no_underflow_stream", underflow, 1'b0);
    repeat (40) @(posedge clk);

    $display("[TB] credit limit with no demand");
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    checkOutput("credit_gnt_count", gnt_log.size(), FIFO_DEPTH);
    for (int i = 0; i < FIFO_DEPTH && i < gnt_log.size(); i++)
      checkOutput("credit_addr", gnt_log[i], BASE_ADDR + 4 * i);
    checkOutput("credit_req_idle", bus.mem_req, 1'b0);
    popPixels(4, 0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("refill_gnt_count", gnt_log.size(), FIFO_DEPTH + 1);
    checkOutput("refill_addr", gnt_log[gnt_log.size() - 1], 56);

    $display("[TB] full frame then overrun");
    popPixels(NUM_PX - 4, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("frame_gnt_count", gnt_log.size(), NUM_WORDS);
    checkOutput("frame_last_addr", gnt_log[gnt_log.size() - 1], BASE_ADDR + 4 * (NUM_WORDS - 1));
    checkOutput("frame_queue_empty", exp_px.size(), 0);
    checkOutput("frame_px_valid", px_valid, 1'b0);
    checkOutput("frame_no_underflow", underflow, 1'b0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("overrun_underflow", underflow, 1'b1);
    checkOutput("overrun_px_data", px_data, 8'h00);
    repeat (10) @(posedge clk);
    checkOutput("done_no_request", gnt_log.size(), NUM_WORDS);

    $display("[TB] restart while a read is outstanding");
    rsp_fixed = 4;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    budget = 100;
    while (gnt_log.size() == 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (budget == 0) checkOutput("restart_gnt_timeout", gnt_log.size(), 1);
    repeat (2) @(posedge clk);
    rv = rvalid_count;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    budget = 50;
    while (rvalid_count == rv && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (budget == 0) checkOutput("stale_rsp_timeout", rvalid_count, rv + 1);
    @(negedge clk);
    checkOutput("stale_dropped", px_valid, 1'b0);
    budget = 50;
    while (gnt_log.size() == 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    checkOutput("restart_addr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hFFFF_FFFF, BASE_ADDR);
    waitValid("restart_valid_timeout");
    popPixels(8, 0);

    $display("[TB] random stalls and restarts");
    rsp_fixed = -1;
    gnt_max   = 7;
    rsp_max   = 7;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0);
      popPixels($urandom_range(1, 150), 2);
    end
    applyStimulus(1, 0);
    popPixels(NUM_PX, 2);
    checkOutput("random_frame_drained", exp_px.size(), 0);

    $display("[TB] asynchronous reset with a request pending");
    gnt_block = 1'b1;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    budget = 50;
    while (!bus.mem_req && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    checkOutput("pre_reset_req", bus.mem_req, 1'b1);
    checkOutput("pre_reset_underflow", underflow, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_mem_req", bus.mem_req, 1'b0);
    checkOutput("arst_mem_addr", bus.mem_addr, BASE_ADDR);
    checkOutput("arst_px_valid", px_valid, 1'b0);
    checkOutput("arst_px_data", px_data, 8'h00);
    checkOutput("arst_underflow", underflow, 1'b0);
    repeat (2) @(posedge clk);
    gnt_block = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_reset", bus.mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Prefetch stage sitting directly upstream of the VGA sync/pattern block. Reads the 8-bit-per-pixel image from the CPU data memory as 32-bit words, buffers them in a small word FIFO, and hands one pixel per request to the display side. Lets the display consume pixels at pixel-clock rate despite variable memory grant/response latency. Also restarts the image at the beginning of each frame.

## Interface
- BASE_ADDR, 24: byte address of pixel 0; must be a multiple of 4
- NUM_PX, 90000: pixels per frame (300x300); must be a multiple of 4
- FIFO_DEPTH, 8: word FIFO entries; power of two, ≥2
- clk  in  1  single clock (pixel clock domain)
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; restarts the image from BASE_ADDR
- px_req  in  1  display pops one pixel this cycle
- px_valid  out  1  a pixel is available at px_data
- px_data  out  8  current pixel; 8'h00 when px_valid=0
- underflow  out  1  sticky: px_req seen while px_valid=0; cleared only by reset
- mem_req  out  1  read request to data memory
- mem_addr  out  32  byte address of the requested word (word-aligned)
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

## Operation
- Fetch FSM states: IDLE, REQ, WAIT, DONE. At most one read outstanding.
- IDLE: waits for frame_start. On frame_start: word pointer = BASE_ADDR, words_issued = 0, go to REQ.
- REQ: mem_req=1, mem_addr = word pointer. Entered only when (fifo_count + 1) ≤ FIFO_DEPTH, counting the outstanding word as occupied. mem_req/mem_addr held stable until mem_gnt. On mem_gnt: pointer += 4, words_issued += 1, go to WAIT.
- WAIT: on mem_rvalid, push mem_rdata into FIFO (unless discard flag set); then go to REQ if words_issued < NUM_PX/4 and FIFO has room, stay parked in a REQ-pending condition otherwise, or DONE if all NUM_PX/4 words issued.
- DONE: no requests until next frame_start.
- Unpacker: little-endian lanes; byte index 0..3 selects mem_rdata[7:0], [15:8], [23:16], [31:24] of the FIFO head. px_valid = FIFO non-empty. On px_req with px_valid: byte index += 1; at index 3, pop head and reset index to 0.
- px_req with px_valid=0: set underflow, no state change.
- frame_start in any state: flush FIFO (count=0), byte index=0, pointer/counters reload, FSM to REQ. If a request is outstanding (WAIT) or held ungranted (REQ), the transaction completes normally on the bus but its data is discarded via a discard flag, and the new frame's first request issues only after that response (or grant+response) retires. frame_start beats px_req in the same cycle: pop ignored, underflow not set.
- Words counter width: ceil(log2(NUM_PX/4 + 1)) bits; pointer 32-bit, no wrap within a frame.

## Timing
- Reset values: mem_req=0, mem_addr=BASE_ADDR, px_valid=0, px_data=8'h00, underflow=0, FSM=IDLE, FIFO empty, byte index 0, discard=0.
- mem_req rises the cycle after entering REQ (registered output); earliest one cycle after frame_start.
- FIFO push on the mem_rvalid edge; px_valid and px_data valid the following cycle (1-cycle rvalid-to-pixel latency).
- px_data is combinational from FIFO head and byte index; updates the cycle after a pop.
- Simultaneous push and pop: count unchanged; push into a full FIFO cannot occur by construction (credit rule).
- Sustained throughput with 1-cycle memory: one word per 3 cycles ≥ one pixel per cycle demand ×4 bytes; FIFO never drains after initial fill.

## Test plan
- Reset then frame_start, memory with gnt same cycle and rvalid next cycle, words 0x44332211, 0x88776655 at 24, 28 -> mem_addr 24 then 28; px_req every cycle yields 0x11,0x22,0x33,0x44,0x55,… with no underflow.
- Hold px_req=0 after frame_start -> exactly FIFO_DEPTH=8 requests issued (addresses 24..52), then mem_req stays 0; one pop of 4 pixels -> one new request to 56.
- Full frame of NUM_PX pops -> last mem_addr = 24+89996, FSM DONE, 90001st px_req sets underflow=1, px_data=8'h00.
- frame_start while in WAIT with rvalid delayed 5 cycles -> stale word dropped, next pixel after restart is byte 0 of address 24, FIFO count 0 before first new response.
- Random mem_gnt/mem_rvalid stalls (0-7 cycles) with random px_req gaps -> pixel stream matches reference memory image byte-exact; mem_addr/mem_req never change while mem_req=1 and mem_gnt=0.
- Assert rst_n low mid-frame with mem_req=1 -> all outputs return to reset values asynchronously; underflow cleared.
